// File: rtl/cuckoo_hash_table.sv
`default_nettype none
// ============================================================================
// Module   : cuckoo_hash_table
// Brief    : N-way cuckoo hash table, H3 hashing, bounded kick FSM, 1-entry stash.
// Revision : 1.0 - initial release
// ============================================================================
module cuckoo_hash_table #(
  parameter int KEY_WIDTH        = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int NUMBER_OF_TABLES = 3,
  parameter int HASH_ADR_WIDTH   = 2,
  parameter int MAX_KICKS        = 4,
  parameter logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH-1:0] Q_MATRIX = 48'h201008040201
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_WIDTH-1:0]  key_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            op_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  no_element_found_o,
  output logic                  no_deletion_target_o,
  output logic                  no_write_space_o,
  output logic                  key_already_present_o,
  output logic [$clog2(NUMBER_OF_TABLES*(2**HASH_ADR_WIDTH)+2)-1:0] count_o
);

  localparam int c_SLOTS = 2**HASH_ADR_WIDTH;
  localparam int c_TW    = $clog2(NUMBER_OF_TABLES);
  localparam int c_KCW   = $clog2(MAX_KICKS+1);
  localparam int c_CW    = $clog2(NUMBER_OF_TABLES*c_SLOTS+2);
  localparam logic [1:0] c_OP_READ  = 2'b01;
  localparam logic [1:0] c_OP_WRITE = 2'b10;
  localparam logic [1:0] c_OP_DEL   = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOOKUP = 2'd1, S_KICK = 2'd2, S_RESP = 2'd3} state_t;

  state_t                  r_state;
  logic [1:0]              r_op;
  logic [KEY_WIDTH-1:0]    r_key, r_carry_key, r_stash_key;
  logic [DATA_WIDTH-1:0]   r_data, r_carry_data, r_stash_data, r_rdata;
  logic [c_TW-1:0]         r_k;
  logic [c_KCW-1:0]        r_kick_cnt;
  logic [c_CW-1:0]         r_count;
  logic                    r_stash_valid, r_ready, r_valid_o;
  logic                    r_nef, r_ndt, r_nws, r_kap;
  logic                    r_tab_valid [NUMBER_OF_TABLES][c_SLOTS];
  logic [KEY_WIDTH-1:0]    r_tab_key   [NUMBER_OF_TABLES][c_SLOTS];
  logic [DATA_WIDTH-1:0]   r_tab_data  [NUMBER_OF_TABLES][c_SLOTS];

  logic [HASH_ADR_WIDTH-1:0] w_addr  [NUMBER_OF_TABLES];
  logic [HASH_ADR_WIDTH-1:0] w_kaddr [NUMBER_OF_TABLES];
  logic [HASH_ADR_WIDTH-1:0] w_hit_slot, w_free_slot, w_kslot;
  logic [c_TW-1:0]           w_hit_tab, w_free_tab, w_k_next;
  logic                      w_hit, w_free, w_stash_hit, w_kfree;

  // Address bit b of table t is the parity of the key masked by H3 row t*HASH_ADR_WIDTH+b.
  function automatic logic [HASH_ADR_WIDTH-1:0] f_hash(input logic [KEY_WIDTH-1:0] key, input int t);
    logic [HASH_ADR_WIDTH-1:0] a;
    a = '0;
    for (int b = 0; b < HASH_ADR_WIDTH; b++)
      a[b] = ^(key & Q_MATRIX[(t*HASH_ADR_WIDTH+b)*KEY_WIDTH +: KEY_WIDTH]);
    return a;
  endfunction

  for (genvar g = 0; g < NUMBER_OF_TABLES; g++) begin : g_hash
    assign w_addr[g]  = f_hash(r_key, g);
    assign w_kaddr[g] = f_hash(r_carry_key, g);
  end

  // Descending scan so the lowest table index wins for both hit and free slot.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_tab  = '0;
    w_free     = 1'b0;
    w_free_tab = '0;
    for (int t = NUMBER_OF_TABLES-1; t >= 0; t--) begin
      if (r_tab_valid[t][w_addr[t]] && (r_tab_key[t][w_addr[t]] == r_key)) begin
        w_hit     = 1'b1;
        w_hit_tab = c_TW'(t);
      end
      if (!r_tab_valid[t][w_addr[t]]) begin
        w_free     = 1'b1;
        w_free_tab = c_TW'(t);
      end
    end
  end

  assign w_hit_slot  = w_addr[w_hit_tab];
  assign w_free_slot = w_addr[w_free_tab];
  assign w_kslot     = w_kaddr[r_k];
  assign w_kfree     = !r_tab_valid[r_k][w_kslot];
  assign w_stash_hit = r_stash_valid && (r_stash_key == r_key);
  assign w_k_next    = (r_k == c_TW'(NUMBER_OF_TABLES-1)) ? '0 : r_k + c_TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_valid_o     <= 1'b0;
      r_rdata       <= '0;
      r_nef         <= 1'b0;
      r_ndt         <= 1'b0;
      r_nws         <= 1'b0;
      r_kap         <= 1'b0;
      r_count       <= '0;
      r_stash_valid <= 1'b0;
      r_k           <= '0;
      r_kick_cnt    <= '0;
      for (int t = 0; t < NUMBER_OF_TABLES; t++)
        for (int s = 0; s < c_SLOTS; s++)
          r_tab_valid[t][s] <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i && r_ready) begin
            r_op    <= op_i;
            r_key   <= key_i;
            r_data  <= data_i;
            r_ready <= 1'b0;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_state   <= S_RESP;
          r_valid_o <= 1'b1;
          case (r_op)
            c_OP_READ: begin
              if (w_hit)            r_rdata <= r_tab_data[w_hit_tab][w_hit_slot];
              else if (w_stash_hit) r_rdata <= r_stash_data;
              else                  r_nef   <= 1'b1;
            end
            c_OP_DEL: begin
              if (w_hit) begin
                r_tab_valid[w_hit_tab][w_hit_slot] <= 1'b0;
                r_count <= r_count - c_CW'(1);
              end else if (w_stash_hit) begin
                r_stash_valid <= 1'b0;
                r_count       <= r_count - c_CW'(1);
              end else begin
                r_ndt <= 1'b1;
              end
            end
            c_OP_WRITE: begin
              if (w_hit) begin
                r_tab_data[w_hit_tab][w_hit_slot] <= r_data;
                r_kap <= 1'b1;
              end else if (w_stash_hit) begin
                r_stash_data <= r_data;
                r_kap        <= 1'b1;
              end else if (w_free) begin
                r_tab_valid[w_free_tab][w_free_slot] <= 1'b1;
                r_tab_key[w_free_tab][w_free_slot]   <= r_key;
                r_tab_data[w_free_tab][w_free_slot]  <= r_data;
                r_count <= r_count + c_CW'(1);
              end else if (r_stash_valid) begin
                r_nws <= 1'b1;
              end else begin
                // Every candidate full: displace T0's occupant and start the kick chain.
                r_tab_key[0][w_addr[0]]  <= r_key;
                r_tab_data[0][w_addr[0]] <= r_data;
                r_carry_key  <= r_tab_key[0][w_addr[0]];
                r_carry_data <= r_tab_data[0][w_addr[0]];
                r_kick_cnt   <= c_KCW'(1);
                r_k          <= c_TW'(1);
                r_state      <= S_KICK;
                r_valid_o    <= 1'b0;
              end
            end
            default: ;
          endcase
        end
        S_KICK: begin
          if (w_kfree) begin
            r_tab_valid[r_k][w_kslot] <= 1'b1;
            r_tab_key[r_k][w_kslot]   <= r_carry_key;
            r_tab_data[r_k][w_kslot]  <= r_carry_data;
            r_count   <= r_count + c_CW'(1);
            r_state   <= S_RESP;
            r_valid_o <= 1'b1;
          end else if (r_kick_cnt == c_KCW'(MAX_KICKS)) begin
            r_stash_valid <= 1'b1;
            r_stash_key   <= r_carry_key;
            r_stash_data  <= r_carry_data;
            r_count       <= r_count + c_CW'(1);
            r_state       <= S_RESP;
            r_valid_o     <= 1'b1;
          end else begin
            r_tab_key[r_k][w_kslot]  <= r_carry_key;
            r_tab_data[r_k][w_kslot] <= r_carry_data;
            r_carry_key  <= r_tab_key[r_k][w_kslot];
            r_carry_data <= r_tab_data[r_k][w_kslot];
            r_kick_cnt   <= r_kick_cnt + c_KCW'(1);
            r_k          <= w_k_next;
          end
        end
        S_RESP: begin
          if (ready_i) begin
            r_valid_o <= 1'b0;
            r_rdata   <= '0;
            r_nef     <= 1'b0;
            r_ndt     <= 1'b0;
            r_nws     <= 1'b0;
            r_kap     <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o               = r_ready;
  assign valid_o               = r_valid_o;
  assign read_data_o           = r_rdata;
  assign no_element_found_o    = r_nef;
  assign no_deletion_target_o  = r_ndt;
  assign no_write_space_o      = r_nws;
  assign key_already_present_o = r_kap;
  assign count_o               = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cuckoo_hash_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_cuckoo_hash_table
// Brief    : Scoreboard bench for cuckoo_hash_table (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cuckoo_hash_table;

  localparam logic [1:0] c_NOP = 2'b00, c_RD = 2'b01, c_WR = 2'b10, c_DEL = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  key_i;
  logic [31:0] data_i;
  logic [1:0]  op_i;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [31:0] read_data_o;
  logic        no_element_found_o, no_deletion_target_o, no_write_space_o, key_already_present_o;
  logic [3:0]  count_o;

  typedef struct packed {
    logic [31:0] rdata;
    logic        nef, ndt, nws, kap;
    logic [3:0]  cnt;
    logic [7:0]  lat;
  } resp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  key;
    logic [31:0] data;
    resp_t       e;
  } stim_t;

  resp_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  cuckoo_hash_table dut (
    .clk(clk), .reset(reset), .key_i(key_i), .data_i(data_i), .op_i(op_i),
    .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .read_data_o(read_data_o), .no_element_found_o(no_element_found_o),
    .no_deletion_target_o(no_deletion_target_o), .no_write_space_o(no_write_space_o),
    .key_already_present_o(key_already_present_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic resp_t mk(input logic [31:0] rd, input logic nef, input logic ndt,
                               input logic nws, input logic kap, input int cnt, input int lat);
    return '{rdata: rd, nef: nef, ndt: ndt, nws: nws, kap: kap, cnt: 4'(cnt), lat: 8'(lat)};
  endfunction

  function automatic stim_t st(input logic [1:0] op, input logic [7:0] key,
                               input logic [31:0] data, input resp_t e);
    return '{op: op, key: key, data: data, e: e};
  endfunction

  task automatic do_reset();
    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    op_i = c_NOP; key_i = '0; data_i = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives one request, pushes its expectation, captures the response (lat=FF on timeout).
  task automatic xact(input stim_t s, output resp_t got);
    int n;
    exp_q.push_back(s.e);
    op_i = s.op; key_i = s.key; data_i = s.data; valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n < 40) begin @(posedge clk); #1; n++; end
    got = '{rdata: read_data_o, nef: no_element_found_o, ndt: no_deletion_target_o,
            nws: no_write_space_o, kap: key_already_present_o, cnt: count_o,
            lat: valid_o ? 8'(n) : 8'hFF};
    if (valid_o && ready_i) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ready_o, valid_o, read_data_o, no_element_found_o, no_deletion_target_o,
         no_write_space_o, key_already_present_o, count_o} !== {2'b10, 32'h0, 4'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset_state ready=%b valid=%b rdata=%h flags=%b%b%b%b count=%0d exp ready=1 rest 0",
               ready_o, valid_o, read_data_o, no_element_found_o, no_deletion_target_o,
               no_write_space_o, key_already_present_o, count_o);
    end
  endtask

  task automatic test_write_read();
    stim_t l[$];
    resp_t got, ex;
    do_reset();
    l.push_back(st(c_WR,  8'h00, 32'hAA, mk(0,     0,0,0,0, 1, 2)));
    l.push_back(st(c_WR,  8'h40, 32'hBB, mk(0,     0,0,0,0, 2, 2)));
    l.push_back(st(c_WR,  8'h80, 32'hCC, mk(0,     0,0,0,0, 3, 2)));
    l.push_back(st(c_RD,  8'h40, 32'h0,  mk(32'hBB,0,0,0,0, 3, 2)));
    l.push_back(st(c_RD,  8'h01, 32'h0,  mk(0,     1,0,0,0, 3, 2)));
    l.push_back(st(c_RD,  8'h80, 32'h0,  mk(32'hCC,0,0,0,0, 3, 2)));
    l.push_back(st(c_NOP, 8'h00, 32'h0,  mk(0,     0,0,0,0, 3, 2)));
    foreach (l[i]) begin
      xact(l[i], got);
      ex = exp_q.pop_front();
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL write_read[%0d] got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_single_kick();
    stim_t l[$];
    resp_t got, ex;
    do_reset();
    l.push_back(st(c_WR, 8'h04, 32'h104, mk(0,      0,0,0,0, 1, 2)));
    l.push_back(st(c_WR, 8'h00, 32'h100, mk(0,      0,0,0,0, 2, 2)));
    l.push_back(st(c_WR, 8'h80, 32'h180, mk(0,      0,0,0,0, 3, 2)));
    l.push_back(st(c_WR, 8'h40, 32'h140, mk(0,      0,0,0,0, 4, 3)));
    l.push_back(st(c_RD, 8'h04, 32'h0,   mk(32'h104,0,0,0,0, 4, 2)));
    l.push_back(st(c_RD, 8'h40, 32'h0,   mk(32'h140,0,0,0,0, 4, 2)));
    foreach (l[i]) begin
      xact(l[i], got);
      ex = exp_q.pop_front();
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL single_kick[%0d] got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_kick_chain_stash();
    stim_t l[$];
    resp_t got, ex;
    do_reset();
    l.push_back(st(c_WR,  8'h00, 32'h200, mk(0,      0,0,0,0, 1, 2)));
    l.push_back(st(c_WR,  8'h40, 32'h240, mk(0,      0,0,0,0, 2, 2)));
    l.push_back(st(c_WR,  8'h80, 32'h280, mk(0,      0,0,0,0, 3, 2)));
    l.push_back(st(c_WR,  8'hC0, 32'h2C0, mk(0,      0,0,0,0, 4, 6)));
    l.push_back(st(c_RD,  8'hC0, 32'h0,   mk(32'h2C0,0,0,0,0, 4, 2)));
    l.push_back(st(c_RD,  8'h00, 32'h0,   mk(32'h200,0,0,0,0, 4, 2)));
    l.push_back(st(c_WR,  8'h90, 32'h290, mk(0,      0,0,0,0, 5, 2)));
    l.push_back(st(c_WR,  8'h50, 32'h250, mk(0,      0,0,1,0, 5, 2)));
    l.push_back(st(c_RD,  8'h50, 32'h0,   mk(0,      1,0,0,0, 5, 2)));
    l.push_back(st(c_WR,  8'h90, 32'hDD,  mk(0,      0,0,0,1, 5, 2)));
    l.push_back(st(c_RD,  8'h90, 32'h0,   mk(32'hDD, 0,0,0,0, 5, 2)));
    l.push_back(st(c_DEL, 8'hC0, 32'h0,   mk(0,      0,0,0,0, 4, 2)));
    l.push_back(st(c_DEL, 8'hC0, 32'h0,   mk(0,      0,1,0,0, 4, 2)));
    l.push_back(st(c_RD,  8'hC0, 32'h0,   mk(0,      1,0,0,0, 4, 2)));
    l.push_back(st(c_RD,  8'h40, 32'h0,   mk(32'h240,0,0,0,0, 4, 2)));
    foreach (l[i]) begin
      xact(l[i], got);
      ex = exp_q.pop_front();
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL kick_chain[%0d] got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  // Continues from the kick-chain state: 0x90 holds DD, count 4.
  task automatic test_backpressure();
    resp_t got, ex;
    ready_i = 1'b0;
    xact(st(c_RD, 8'h90, 32'h0, mk(32'hDD, 0,0,0,0, 4, 2)), got);
    ex = exp_q.pop_front();
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL backpressure_first got=%h exp=%h", got, ex);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if ({valid_o, ready_o, read_data_o, no_element_found_o, count_o} !== {2'b10, 32'hDD, 1'b0, 4'd4}) begin
        bad++;
        $display("FAIL backpressure_hold[%0d] valid=%b ready=%b rdata=%h nef=%b count=%0d exp valid=1 ready=0 rdata=dd nef=0 count=4",
                 c, valid_o, ready_o, read_data_o, no_element_found_o, count_o);
      end
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({valid_o, ready_o, read_data_o} !== {2'b01, 32'h0}) begin
      bad++;
      $display("FAIL backpressure_release valid=%b ready=%b rdata=%h exp valid=0 ready=1 rdata=0",
               valid_o, ready_o, read_data_o);
    end
  endtask

  task automatic test_mid_reset();
    stim_t l[$];
    resp_t got, ex;
    do_reset();
    l.push_back(st(c_WR, 8'h00, 32'h300, mk(0, 0,0,0,0, 1, 2)));
    l.push_back(st(c_WR, 8'h40, 32'h340, mk(0, 0,0,0,0, 2, 2)));
    l.push_back(st(c_WR, 8'h80, 32'h380, mk(0, 0,0,0,0, 3, 2)));
    foreach (l[i]) begin
      xact(l[i], got);
      ex = exp_q.pop_front();
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL mid_reset_fill[%0d] got=%h exp=%h", i, got, ex);
      end
    end
    op_i = c_WR; key_i = 8'hC0; data_i = 32'h3C0; valid_i = 1'b1;
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    total++;
    if ({ready_o, valid_o, count_o} !== {2'b10, 4'd0}) begin
      bad++;
      $display("FAIL mid_reset_state ready=%b valid=%b count=%0d exp ready=1 valid=0 count=0",
               ready_o, valid_o, count_o);
    end
    l.delete();
    l.push_back(st(c_RD, 8'h00, 32'h0,   mk(0, 1,0,0,0, 0, 2)));
    l.push_back(st(c_RD, 8'hC0, 32'h0,   mk(0, 1,0,0,0, 0, 2)));
    l.push_back(st(c_WR, 8'h00, 32'h301, mk(0, 0,0,0,0, 1, 2)));
    foreach (l[i]) begin
      xact(l[i], got);
      ex = exp_q.pop_front();
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL mid_reset_after[%0d] got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_single_kick();
    test_kick_chain_stash();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
